// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared constants and slow-clock level type for the Morse divider
package morse_pkg;

  localparam int CLK_HZ                 = 50_000_000;
  localparam int MORSE_DIV_HALF_DEFAULT = CLK_HZ / 20;
  localparam int MORSE_CNT_W            = 32;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } morse_level_e;

endpackage

// File: rtl/morse_div_counter.sv
// rtl/morse_div_counter.sv - terminal-count counter; wrap marks the last cycle of a half-period
import morse_pkg::*;

module morse_div_counter #(
  parameter int CNT_W = MORSE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] half,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;

  // load suppresses wrap so a reprogramming cycle never toggles the output
  assign wrap = en && !load && (cnt == half - CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/morse_clk_divider.sv
// rtl/morse_clk_divider.sv - 50% duty slow_clock plus rising-edge tick strobe
// Optional runtime divisor load: define MORSE_DIVIDER_PROG_EN.
import morse_pkg::*;

module morse_clk_divider #(
  parameter int HALF_PERIOD = MORSE_DIV_HALF_DEFAULT,
  parameter int CNT_W       = MORSE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
`ifdef MORSE_DIVIDER_PROG_EN
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_half,
`endif
  output logic             slow_clock,
  output logic             tick
);

  morse_level_e     state, next_state;
  logic             tick_next;
  logic             wrap;
  logic             load;
  logic [CNT_W-1:0] half;

`ifdef MORSE_DIVIDER_PROG_EN
  assign load = div_load;

  // a zero divisor would never reach terminal count, so treat it as 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half <= CNT_W'(HALF_PERIOD);
    end else if (div_load) begin
      half <= (div_half == '0) ? CNT_W'(1) : div_half;
    end
  end
`else
  assign load = 1'b0;
  assign half = CNT_W'(HALF_PERIOD);
`endif

  morse_div_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .load  (load),
    .half  (half),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOW;
      tick  <= 1'b0;
    end else begin
      state <= next_state;
      tick  <= tick_next;
    end
  end

  always_comb begin
    next_state = state;
    tick_next  = 1'b0;
    if (wrap) begin
      next_state = (state == LOW) ? HIGH : LOW;
      tick_next  = (state == LOW);
    end
  end

  assign slow_clock = (state == HIGH);

endmodule

// File: tb/tb_morse_clk_divider.sv
// tb/tb_morse_clk_divider.sv - directed self-checking bench for morse_clk_divider
// Prog-load steps are included when MORSE_DIVIDER_PROG_EN is defined.
module tb_morse_clk_divider;

  logic       clk;
  logic       reset;
  logic       en4;
  logic       en1;
  logic       slow4, tick4;
  logic       slow1, tick1;
  logic       div_load;
  logic [7:0] div_half;
  int         compared;
  int         mismatched;

  morse_clk_divider #(.HALF_PERIOD(4), .CNT_W(8)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .en         (en4),
`ifdef MORSE_DIVIDER_PROG_EN
    .div_load   (div_load),
    .div_half   (div_half),
`endif
    .slow_clock (slow4),
    .tick       (tick4)
  );

  morse_clk_divider #(.HALF_PERIOD(1), .CNT_W(8)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .en         (en1),
`ifdef MORSE_DIVIDER_PROG_EN
    .div_load   (1'b0),
    .div_half   (8'd0),
`endif
    .slow_clock (slow1),
    .tick       (tick1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    en4        = 1'b1;
    en1        = 1'b1;
    div_load   = 1'b0;
    div_half   = 8'd0;

    repeat (2) edge_step();
    check("rst_slow4", slow4, 1'b0);
    check("rst_tick4", tick4, 1'b0);
    check("rst_slow1", slow1, 1'b0);
    check("rst_tick1", tick1, 1'b0);
    reset = 1'b0;

    // free run: half=4 rises at 4, falls at 8; half=1 toggles every edge
    for (int k = 1; k <= 20; k++) begin
      edge_step();
      check("run_slow4", slow4, ((k / 4) % 2) == 1);
      check("run_tick4", tick4, (k % 8) == 4);
      check("run_slow1", slow1, (k % 2) == 1);
      check("run_tick1", tick1, (k % 2) == 1);
    end

    // edge 21 is inside the HIGH half; reset asynchronously mid-cycle
    edge_step();
    check("mid_high", slow4, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_slow", slow4, 1'b0);
    check("async_rst_tick", tick4, 1'b0);
    edge_step();
    reset = 1'b0;

    for (int k = 1; k <= 10; k++) begin
      edge_step();
      check("rerun_slow", slow4, (k >= 4) && (k < 8));
      check("rerun_tick", tick4, k == 4);
    end

    // cnt=2 in LOW half: pause 3 cycles, rise moves from edge 12 to 15
    en4 = 1'b0;
    for (int k = 11; k <= 13; k++) begin
      edge_step();
      check("pause_slow", slow4, 1'b0);
      check("pause_tick", tick4, 1'b0);
    end
    en4 = 1'b1;
    edge_step();
    check("e14_slow", slow4, 1'b0);
    edge_step();
    check("e15_slow", slow4, 1'b1);
    check("e15_tick", tick4, 1'b1);
    edge_step();
    check("e16_tick", tick4, 1'b0);
    edge_step();
    edge_step();

    // terminal count reached, enable dropped: the fall waits for en
    en4 = 1'b0;
    edge_step();
    check("tc_hold_slow", slow4, 1'b1);
    en4 = 1'b1;
    edge_step();
    check("tc_fall_slow", slow4, 1'b0);
    check("tc_fall_tick", tick4, 1'b0);

`ifdef MORSE_DIVIDER_PROG_EN
    reset = 1'b1;
    edge_step();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      edge_step();
      check("pre_load_slow", slow4, k >= 4);
    end
    div_load = 1'b1;
    div_half = 8'd2;
    edge_step();
    div_load = 1'b0;
    check("load_keep_slow", slow4, 1'b1);
    check("load_tick", tick4, 1'b0);
    edge_step();
    check("e7_slow", slow4, 1'b1);
    edge_step();
    check("e8_fall", slow4, 1'b0);
    edge_step();
    check("e9_slow", slow4, 1'b0);
    edge_step();
    check("e10_rise", slow4, 1'b1);
    check("e10_tick", tick4, 1'b1);
    edge_step();
    edge_step();
    check("e12_fall", slow4, 1'b0);

    div_load = 1'b1;
    div_half = 8'd0;
    edge_step();
    div_load = 1'b0;
    check("load0_keep", slow4, 1'b0);
    for (int k = 14; k <= 17; k++) begin
      edge_step();
      check("half1_slow", slow4, (k % 2) == 0);
      check("half1_tick", tick4, (k % 2) == 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
